// File: rtl/recip_nr_stream.sv
// Streaming unsigned fixed-point reciprocal: leading-one normalisation, linear seed,
// unrolled Newton-Raphson refinement and a round/saturate back end, one operand per cycle.
module recip_nr_stream #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned A_FRAC_BITS    = 4,
  parameter int unsigned INV_FRAC_BITS  = 28,
  parameter int unsigned NUM_ITERATIONS = 3,
  parameter int unsigned TAG_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_A,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_A_inv,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_div_zero,
  output logic                  out_overflow
);

  localparam int unsigned W    = DATA_WIDTH + 2;  // internal fraction bits
  localparam int unsigned XW   = W + 2;           // unsigned 2.W estimate
  localparam int unsigned PW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned NI   = NUM_ITERATIONS;
  localparam int unsigned MulW = 2 * XW;
  localparam int unsigned RW   = XW + 2;
  localparam int unsigned LW   = XW + DATA_WIDTH + 1;
  localparam int          ShBase = int'(A_FRAC_BITS + INV_FRAC_BITS) - 1 - int'(W);
  localparam logic [XW-1:0] SeedK = XW'(longint'(2.9142 * (2.0 ** W)));

  logic adv;

  // Normalisation stage
  logic                 nv_q, nv_d;
  logic [W-1:0]         nm_q, nm_d;
  logic [PW-1:0]        np_q, np_d;
  logic                 nz_q, nz_d;
  logic [TAG_WIDTH-1:0] nt_q, nt_d;

  // Index 0 is the seed stage, 1..NI the Newton-Raphson stages
  logic                 sv_q [NI+1];
  logic                 sv_d [NI+1];
  logic [XW-1:0]        sx_q [NI+1];
  logic [XW-1:0]        sx_d [NI+1];
  logic [W-1:0]         sm_q [NI];
  logic [W-1:0]         sm_d [NI];
  logic [PW-1:0]        sp_q [NI+1];
  logic [PW-1:0]        sp_d [NI+1];
  logic                 sz_q [NI+1];
  logic                 sz_d [NI+1];
  logic [TAG_WIDTH-1:0] st_q [NI+1];
  logic [TAG_WIDTH-1:0] st_d [NI+1];

  // Output stage
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_a_inv_q, out_a_inv_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic                  out_dz_q, out_dz_d;
  logic                  out_ovf_q, out_ovf_d;

  logic [PW-1:0]         lod_p;
  logic [DATA_WIDTH-1:0] scaled;
  logic                  scale_ovf;
  logic [RW-1:0]         rnd_sum;
  logic [LW-1:0]         lsh;
  int                    sh;
  int                    rs;

  assign adv          = !(out_valid_q && !out_ready);
  assign in_ready     = adv;
  assign out_valid    = out_valid_q;
  assign out_A_inv    = out_a_inv_q;
  assign out_tag      = out_tag_q;
  assign out_div_zero = out_dz_q;
  assign out_overflow = out_ovf_q;

  // X <= X * (2 - m*X), both products truncated to W fraction bits
  function automatic logic [XW-1:0] nr_step(input logic [W-1:0] m, input logic [XW-1:0] x);
    logic [XW-1:0] mx;
    logic [XW-1:0] t;
    mx = XW'((MulW'(m) * MulW'(x)) >> W);
    t  = {2'b10, {W{1'b0}}} - mx;
    return XW'((MulW'(x) * MulW'(t)) >> W);
  endfunction

  always_comb begin
    lod_p = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (in_A[i]) lod_p = PW'(i);
    end
  end

  always_comb begin
    nv_d = nv_q;
    nm_d = nm_q;
    np_d = np_q;
    nz_d = nz_q;
    nt_d = nt_q;
    if (adv) begin
      nv_d = in_valid;
      np_d = lod_p;
      nz_d = (in_A == '0);
      nt_d = in_tag;
      // Leading one lands on bit W-1 (weight 0.5); a zero operand uses exactly 0.5
      if (in_A == '0) nm_d = {1'b1, {(W-1){1'b0}}};
      else            nm_d = W'(in_A) << (int'(W) - 1 - int'(lod_p));
    end
  end

  always_comb begin
    for (int k = 0; k <= int'(NI); k++) begin
      sv_d[k] = sv_q[k];
      sx_d[k] = sx_q[k];
      sp_d[k] = sp_q[k];
      sz_d[k] = sz_q[k];
      st_d[k] = st_q[k];
    end
    for (int k = 0; k < int'(NI); k++) begin
      sm_d[k] = sm_q[k];
    end
    if (adv) begin
      sv_d[0] = nv_q;
      sx_d[0] = SeedK - XW'({nm_q, 1'b0});
      sm_d[0] = nm_q;
      sp_d[0] = np_q;
      sz_d[0] = nz_q;
      st_d[0] = nt_q;
      for (int k = 1; k <= int'(NI); k++) begin
        sv_d[k] = sv_q[k-1];
        sx_d[k] = nr_step(sm_q[k-1], sx_q[k-1]);
        sp_d[k] = sp_q[k-1];
        sz_d[k] = sz_q[k-1];
        st_d[k] = st_q[k-1];
      end
      for (int k = 1; k < int'(NI); k++) begin
        sm_d[k] = sm_q[k-1];
      end
    end
  end

  // Scale X by 2^(ShBase - p): round-half-up on right shifts, exact on left shifts
  always_comb begin
    scaled    = '0;
    scale_ovf = 1'b0;
    rnd_sum   = '0;
    lsh       = '0;
    rs        = 0;
    sh        = ShBase - int'(sp_q[NI]);
    if (sh < 0) begin
      rs        = (-sh > int'(XW) + 1) ? int'(XW) + 1 : -sh;
      rnd_sum   = RW'(sx_q[NI]) + (RW'(1) << (rs - 1));
      rnd_sum   = rnd_sum >> rs;
      scale_ovf = (rnd_sum >> DATA_WIDTH) != '0;
      scaled    = DATA_WIDTH'(rnd_sum);
    end else if (sh > int'(DATA_WIDTH)) begin
      // X >= 0.5 for any nonzero operand, so this shift always leaves the range
      scale_ovf = 1'b1;
    end else begin
      lsh       = LW'(sx_q[NI]) << sh;
      scale_ovf = (lsh >> DATA_WIDTH) != '0;
      scaled    = DATA_WIDTH'(lsh);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_inv_d = out_a_inv_q;
    out_tag_d   = out_tag_q;
    out_dz_d    = out_dz_q;
    out_ovf_d   = out_ovf_q;
    if (adv) begin
      out_valid_d = sv_q[NI];
      out_tag_d   = st_q[NI];
      out_dz_d    = sz_q[NI];
      out_ovf_d   = 1'b0;
      out_a_inv_d = scaled;
      if (sz_q[NI]) begin
        out_a_inv_d = '1;
      end else if (scale_ovf) begin
        out_a_inv_d = '1;
        out_ovf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      nv_q        <= 1'b0;
      for (int k = 0; k <= int'(NI); k++) sv_q[k] <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_inv_q <= '0;
      out_tag_q   <= '0;
      out_dz_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      nv_q        <= nv_d;
      for (int k = 0; k <= int'(NI); k++) sv_q[k] <= sv_d[k];
      out_valid_q <= out_valid_d;
      out_a_inv_q <= out_a_inv_d;
      out_tag_q   <= out_tag_d;
      out_dz_q    <= out_dz_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    nm_q <= nm_d;
    np_q <= np_d;
    nz_q <= nz_d;
    nt_q <= nt_d;
    for (int k = 0; k <= int'(NI); k++) begin
      sx_q[k] <= sx_d[k];
      sp_q[k] <= sp_d[k];
      sz_q[k] <= sz_d[k];
      st_q[k] <= st_d[k];
    end
    for (int k = 0; k < int'(NI); k++) begin
      sm_q[k] <= sm_d[k];
    end
  end

endmodule

// File: tb/tb_recip_nr_stream.sv
// Directed bench for recip_nr_stream: latency, edge values, streaming, backpressure,
// mid-flight reset, plus a narrow 16-bit integer-input instance.
module tb_recip_nr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, in_valid, in_ready, out_valid, out_ready, out_div_zero, out_overflow;
  logic [31:0] in_A, out_A_inv;
  logic [7:0]  in_tag, out_tag;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_dz, n_ovf;
  logic [15:0] n_in_A, n_out;
  logic [3:0]  n_in_tag, n_out_tag;

  int n_checks = 0;
  int n_errors = 0;

  recip_nr_stream dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_A_inv(out_A_inv),
    .out_tag(out_tag), .out_div_zero(out_div_zero), .out_overflow(out_overflow)
  );

  recip_nr_stream #(
    .DATA_WIDTH(16), .A_FRAC_BITS(0), .INV_FRAC_BITS(15), .NUM_ITERATIONS(3), .TAG_WIDTH(4)
  ) dut_n (
    .clk(clk), .rstn(rstn), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_A(n_in_A),
    .in_tag(n_in_tag), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_A_inv(n_out),
    .out_tag(n_out_tag), .out_div_zero(n_dz), .out_overflow(n_ovf)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // {div_zero, overflow, round(2^32 / A) ties up}
  function automatic logic [33:0] model(input logic [31:0] a);
    longint unsigned r;
    if (a == 32'h0) return {2'b10, 32'hFFFF_FFFF};
    r = ((64'd1 << 33) / 64'(a) + 64'd1) >> 1;
    if (r > 64'hFFFF_FFFF) return {2'b01, 32'hFFFF_FFFF};
    return {2'b00, r[31:0]};
  endfunction

  task automatic check_res(input string name, input logic [31:0] a, input logic [31:0] got,
                           input logic dz, input logic ovf);
    logic [33:0] m;
    logic [31:0] diff;
    m = model(a);
    check({name, "_dz"}, 64'(dz), 64'(m[33]));
    check({name, "_ovf"}, 64'(ovf), 64'(m[32]));
    if (m[33] || m[32]) begin
      check({name, "_val"}, 64'(got), 64'(m[31:0]));
    end else begin
      diff = (got > m[31:0]) ? got - m[31:0] : m[31:0] - got;
      n_checks++;
      assert (diff <= 32'd1) else begin
        n_errors++;
        $error("FAIL %s_val: observed %0h expected %0h within 1", name, got, m[31:0]);
      end
    end
  endtask

  task automatic single(input logic [31:0] a, input logic [7:0] tag, input logic [31:0] exp,
                        input logic exp_dz, input logic exp_ovf, input string name);
    @(negedge clk);
    in_valid = 1'b1;
    in_A     = a;
    in_tag   = tag;
    #1 check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) check({name, "_early"}, 64'(out_valid), 64'd0);
    end
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_val"}, 64'(out_A_inv), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    check({name, "_dz"}, 64'(out_div_zero), 64'(exp_dz));
    check({name, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
  endtask

  task automatic narrow(input logic [15:0] a, input logic [15:0] exp, input logic exp_dz,
                        input logic exp_ovf, input string name);
    @(negedge clk);
    n_in_valid = 1'b1;
    n_in_A     = a;
    n_in_tag   = a[3:0];
    @(negedge clk);
    n_in_valid = 1'b0;
    for (int i = 0; i < 20 && !n_out_valid; i++) @(negedge clk);
    check({name, "_valid"}, 64'(n_out_valid), 64'd1);
    check({name, "_val"}, 64'(n_out), 64'(exp));
    check({name, "_tag"}, 64'(n_out_tag), 64'(a[3:0]));
    check({name, "_dz"}, 64'(n_dz), 64'(exp_dz));
    check({name, "_ovf"}, 64'(n_ovf), 64'(exp_ovf));
    @(negedge clk);
  endtask

  function automatic logic [31:0] bp_operand(input int n);
    if (n == 5)  return 32'h0;
    if (n == 11) return 32'h1;
    return 32'h0000_0123 * 32'(n + 1) + (32'(n) << 20);
  endfunction

  logic [31:0] s_a [16];
  logic [31:0] h_val;
  logic [7:0]  h_tag;
  logic        h_dz, h_ovf, stalled;
  int          first, rcv, b_sent, b_rcv, stale;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_A = '0; in_tag = '0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_A = '0; n_in_tag = '0; n_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_val", 64'(out_A_inv), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_flags", 64'({out_div_zero, out_overflow}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single operations and edge values
    single(32'h0000_0010, 8'h01, 32'h1000_0000, 1'b0, 1'b0, "a_one");
    single(32'h0000_0020, 8'h02, 32'h0800_0000, 1'b0, 1'b0, "a_two");
    single(32'h0000_0030, 8'h03, 32'h0555_5555, 1'b0, 1'b0, "a_three");
    single(32'h0000_0000, 8'h04, 32'hFFFF_FFFF, 1'b1, 1'b0, "a_zero");
    single(32'h0000_0001, 8'h05, 32'hFFFF_FFFF, 1'b0, 1'b1, "a_lsb");
    single(32'h0000_0002, 8'h06, 32'h8000_0000, 1'b0, 1'b0, "a_2lsb");
    single(32'hFFFF_FFFF, 8'h07, 32'h0000_0001, 1'b0, 1'b0, "a_max");

    // Back-to-back stream of 16 operands
    for (int i = 0; i < 16; i++) s_a[i] = 32'h0000_0040 + 32'(i) * 32'h0003_1A2B;
    first = -1;
    rcv   = 0;
    for (int c = 0; c < 40 && rcv < 16; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = c;
        check("stream_contig", 64'(c - first), 64'(rcv));
        check("stream_tag", 64'(out_tag), 64'(rcv));
        check_res("stream", s_a[rcv], out_A_inv, out_div_zero, out_overflow);
        rcv++;
      end
      in_valid = (c < 16);
      if (c < 16) begin
        in_A   = s_a[c];
        in_tag = 8'(c);
      end
    end
    in_valid = 1'b0;
    check("stream_count", 64'(rcv), 64'd16);

    // Backpressure with random and long stalls
    b_sent  = 0;
    b_rcv   = 0;
    stalled = 1'b0;
    h_val = '0; h_tag = '0; h_dz = 1'b0; h_ovf = 1'b0;
    for (int c = 0; c < 3000 && b_rcv < 24; c++) begin
      @(negedge clk);
      out_ready = (c >= 30 && c < 55) ? 1'b0 : ($urandom_range(0, 2) != 0);
      in_valid  = (b_sent < 24);
      in_A      = bp_operand(b_sent);
      in_tag    = 8'h40 + 8'(b_sent);
      #1;
      if (stalled) begin
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_val", 64'(out_A_inv), 64'(h_val));
        check("bp_hold_tag", 64'(out_tag), 64'(h_tag));
        check("bp_hold_flags", 64'({out_div_zero, out_overflow}), 64'({h_dz, h_ovf}));
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        h_val = out_A_inv; h_tag = out_tag; h_dz = out_div_zero; h_ovf = out_overflow;
      end
      if (out_valid && out_ready) begin
        check("bp_tag", 64'(out_tag), 64'(8'h40 + 8'(b_rcv)));
        check_res("bp", bp_operand(b_rcv), out_A_inv, out_div_zero, out_overflow);
        b_rcv++;
      end
      if (in_valid && in_ready) b_sent++;
    end
    check("bp_count", 64'(b_rcv), 64'd24);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("bp_no_extra", 64'(stale), 64'd0);

    // Reset with four operands in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_A     = 32'h100 * 32'(i + 1);
      in_tag   = 8'h80 + 8'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rstn     = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_val", 64'(out_A_inv), 64'd0);
    rstn = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mrst_no_stale", 64'(stale), 64'd0);
    single(32'h0000_0030, 8'h99, 32'h0555_5555, 1'b0, 1'b0, "post_rst");

    // 16-bit integer input, Q1.15 output
    narrow(16'd1,      16'h8000, 1'b0, 1'b0, "n_one");
    narrow(16'd2,      16'h4000, 1'b0, 1'b0, "n_two");
    narrow(16'd3,      16'h2AAB, 1'b0, 1'b0, "n_three");
    narrow(16'hFFFF,   16'h0001, 1'b0, 1'b0, "n_max");
    narrow(16'd0,      16'hFFFF, 1'b1, 1'b0, "n_zero");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
